// File: rtl/core_mem_arbiter_nport.sv
// core_mem_arbiter_nport
//   N-requester memory arbiter and ROM/RAM address decoder. One transaction
//   is in flight at a time: IDLE (grant) -> ACCESS (target access) -> RESP
//   (ack and read data). The arbiter uses fixed or round-robin priority.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_clk_en          global enable; low freezes the FSM and all registers
//   i_req/i_we        per-port request and write flag
//   i_addr/i_be/i_wdata  per-port byte address, byte enables, write data
//   o_gnt             one-hot, request accepted this cycle
//   o_ack/o_err       one-hot completion pulse; error flag valid with it
//   o_rdata           read data returned with o_ack
//   o_busy            transaction in ACCESS or RESP
//   o_rom_addr        ROM word address; i_rom_rdata is its 1-cycle read data
//   o_ram_*           RAM word address, write strobe, byte enables, write data
//   i_ram_rdata       RAM 1-cycle read data
module core_mem_arbiter_nport #(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   DW        = 32,
    parameter int unsigned   NPORTS    = 3,
    parameter bit            ARB_RR    = 1'b0,
    parameter logic [AW-1:0] ROM_BASE  = AW'(32'h0000_0000),
    parameter int unsigned   ROM_BYTES = 2048,
    parameter logic [AW-1:0] RAM_BASE  = AW'(32'h0000_1000),
    parameter int unsigned   RAM_BYTES = 16384
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_en,
    input  logic [NPORTS-1:0]      i_req,
    input  logic [NPORTS-1:0]      i_we,
    input  logic [NPORTS*AW-1:0]   i_addr,
    input  logic [NPORTS*DW/8-1:0] i_be,
    input  logic [NPORTS*DW-1:0]   i_wdata,
    output logic [NPORTS-1:0]      o_gnt,
    output logic [NPORTS-1:0]      o_ack,
    output logic                   o_err,
    output logic [DW-1:0]          o_rdata,
    output logic                   o_busy,
    output logic [AW-1:0]          o_rom_addr,
    input  logic [DW-1:0]          i_rom_rdata,
    output logic [AW-1:0]          o_ram_addr,
    output logic                   o_ram_we,
    output logic [DW/8-1:0]        o_ram_be,
    output logic [DW-1:0]          o_ram_wdata,
    input  logic [DW-1:0]          i_ram_rdata
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFFS = (BW > 1) ? $clog2(BW) : 0;
    localparam int unsigned PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    // Region bounds carried at AW+1 bits so base+size cannot wrap.
    localparam logic [AW:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [AW:0] ROM_HI = ROM_LO + (AW+1)'(ROM_BYTES);
    localparam logic [AW:0] RAM_LO = {1'b0, RAM_BASE};
    localparam logic [AW:0] RAM_HI = RAM_LO + (AW+1)'(RAM_BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_q, win_d;
    logic          we_q, we_d;
    logic [BW-1:0] be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] word_q, word_d;
    logic          rom_sel_q, rom_sel_d;
    logic          ram_sel_q, ram_sel_d;
    logic          err_q, err_d;

    // ---------------- arbitration ----------------
    logic [PW-1:0] win;
    logic [PW-1:0] cand;
    logic          req_any;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        win     = '0;
        cand    = '0;
        req_any = 1'b0;
        // Scan from ptr in round-robin mode, from port 0 in fixed mode;
        // the first asserted request found wins.
        for (int i = 0; i < NPORTS; i++) begin
            if (ARB_RR) cand = PW'((int'(ptr_q) + i) % NPORTS);
            else        cand = PW'(i);
            if (!req_any && i_req[cand]) begin
                req_any = 1'b1;
                win     = cand;
            end
        end
    end

    // ---------------- decode of the winning request ----------------
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic          rom_hit, ram_hit, dec_err;
    logic [AW-1:0] rom_word, ram_word;

    always_comb begin
        sel_addr = i_addr[win*AW +: AW];
        sel_we   = i_we[win];
        rom_hit  = ({1'b0, sel_addr} >= ROM_LO) && ({1'b0, sel_addr} < ROM_HI);
        ram_hit  = !rom_hit && ({1'b0, sel_addr} >= RAM_LO) && ({1'b0, sel_addr} < RAM_HI);
        rom_word = (sel_addr - ROM_BASE) >> OFFS;
        ram_word = (sel_addr - RAM_BASE) >> OFFS;
        dec_err  = (sel_addr[1:0] != 2'b00) || !(rom_hit || ram_hit) || (rom_hit && sel_we);
    end

    // ---------------- FSM next state and request capture ----------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        rom_sel_d = rom_sel_q;
        ram_sel_d = ram_sel_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d   = ST_ACCESS;
                    win_d     = win;
                    we_d      = sel_we;
                    be_d      = i_be[win*BW +: BW];
                    wdata_d   = i_wdata[win*DW +: DW];
                    word_d    = rom_hit ? rom_word : ram_word;
                    // An erroring request selects no target at all.
                    rom_sel_d = rom_hit && !dec_err;
                    ram_sel_d = ram_hit && !dec_err;
                    err_d     = dec_err;
                    if (ARB_RR) ptr_d = (win == PW'(NPORTS - 1)) ? '0 : win + 1'b1;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: the request datapath is deliberately not reset; every output it
    // feeds is qualified by the FSM state, which is.
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            win_q     <= win_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            word_q    <= word_d;
            rom_sel_q <= rom_sel_d;
            ram_sel_q <= ram_sel_d;
            err_q     <= err_d;
        end
    end

    // ---------------- outputs ----------------
    logic active, in_resp, grant;

    assign active  = (state_q != ST_IDLE);
    assign in_resp = (state_q == ST_RESP) && !i_rst;
    assign grant   = (state_q == ST_IDLE) && req_any && i_clk_en && !i_rst;

    assign o_gnt  = grant ? (NPORTS'(1) << win) : '0;
    assign o_ack  = (in_resp && i_clk_en) ? (NPORTS'(1) << win_q) : '0;
    assign o_err  = in_resp && err_q;
    assign o_busy = active;

    // Target addresses stay valid through RESP so a stalled RESP keeps the
    // synchronous read data stable.
    assign o_rom_addr  = (active && rom_sel_q) ? word_q : '0;
    assign o_ram_addr  = (active && ram_sel_q) ? word_q : '0;
    assign o_ram_be    = (active && ram_sel_q && we_q) ? be_q : '0;
    assign o_ram_wdata = (active && ram_sel_q && we_q) ? wdata_q : '0;
    assign o_ram_we    = (state_q == ST_ACCESS) && ram_sel_q && we_q && i_clk_en && !i_rst;

    always_comb begin
        o_rdata = '0;
        if (in_resp && !we_q) begin
            if (rom_sel_q)      o_rdata = i_rom_rdata;
            else if (ram_sel_q) o_rdata = i_ram_rdata;
        end
    end

endmodule

// File: tb/tb_core_mem_arbiter_nport.sv
// Self-checking bench for core_mem_arbiter_nport: a table of single
// transactions plus hand-written sequences for arbitration order, clock
// enable stalls and reset during a write.
module tb_core_mem_arbiter_nport;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_clk_en = 1'b1;
    logic [2:0]  i_req = '0;
    logic [2:0]  i_we = '0;
    logic [95:0] i_addr = '0;
    logic [11:0] i_be = '0;
    logic [95:0] i_wdata = '0;

    logic [2:0]  o_gnt, o_ack;
    logic        o_err, o_busy, o_ram_we;
    logic [31:0] o_rdata, o_rom_addr, o_ram_addr, o_ram_wdata;
    logic [3:0]  o_ram_be;
    logic [31:0] rom_rdata = '0;
    logic [31:0] ram_rdata = '0;

    logic [2:0]  rr_gnt, rr_ack;
    logic        rr_err, rr_busy, rr_ram_we;
    logic [31:0] rr_rdata, rr_rom_addr, rr_ram_addr, rr_ram_wdata;
    logic [3:0]  rr_ram_be;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    core_mem_arbiter_nport dut (
        .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be), .i_wdata(i_wdata),
        .o_gnt(o_gnt), .o_ack(o_ack), .o_err(o_err), .o_rdata(o_rdata), .o_busy(o_busy),
        .o_rom_addr(o_rom_addr), .i_rom_rdata(rom_rdata),
        .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_be(o_ram_be),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
    );

    core_mem_arbiter_nport #(.ARB_RR(1'b1)) dut_rr (
        .i_clk(clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_be(i_be), .i_wdata(i_wdata),
        .o_gnt(rr_gnt), .o_ack(rr_ack), .o_err(rr_err), .o_rdata(rr_rdata), .o_busy(rr_busy),
        .o_rom_addr(rr_rom_addr), .i_rom_rdata(32'h0),
        .o_ram_addr(rr_ram_addr), .o_ram_we(rr_ram_we), .o_ram_be(rr_ram_be),
        .o_ram_wdata(rr_ram_wdata), .i_ram_rdata(32'h0)
    );

    // ROM model: word k reads as 32'hA000_0000 | k.
    always @(posedge clk) rom_rdata <= 32'hA000_0000 | o_rom_addr;

    // Byte-enabled RAM model, 4096 words, read-before-write.
    logic [31:0] ram [0:4095];
    initial for (int i = 0; i < 4096; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (o_ram_we)
            for (int b = 0; b < 4; b++)
                if (o_ram_be[b]) ram[o_ram_addr[11:0]][b*8 +: 8] <= o_ram_wdata[b*8 +: 8];
        ram_rdata <= ram[o_ram_addr[11:0]];
    end

    always @(negedge clk) if (o_ram_we) we_cnt <= we_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] rom_a;
        logic [31:0] ram_a;
        logic        ram_we;
    } vec_t;

    function automatic vec_t mk(input string name, input int port, input logic we,
                                input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic err,
                                input logic [31:0] rdata, input logic [31:0] rom_a,
                                input logic [31:0] ram_a, input logic ram_we);
        vec_t v;
        v.name = name; v.port = port; v.we = we; v.addr = addr; v.be = be;
        v.wdata = wdata; v.err = err; v.rdata = rdata; v.rom_a = rom_a;
        v.ram_a = ram_a; v.ram_we = ram_we;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        i_we[p]             = we;
        i_addr[p*32 +: 32]  = addr;
        i_be[p*4 +: 4]      = be;
        i_wdata[p*32 +: 32] = wd;
        i_req[p]            = 1'b1;
    endtask

    // One full transaction from an idle DUT: gnt, ACCESS, RESP, back to IDLE.
    task automatic run_txn(input vec_t v);
        int n;
        drive(v.port, v.we, v.addr, v.be, v.wdata);
        #1;
        n = 0;
        while (o_gnt == 3'b000 && n < 8) begin
            cyc(); #1; n++;
        end
        check({v.name, "_gnt"}, 32'(o_gnt), 32'(3'b001 << v.port));
        cyc();
        i_req = '0;
        #1;
        check({v.name, "_busy_access"}, 32'(o_busy), 32'd1);
        check({v.name, "_ram_we"}, 32'(o_ram_we), 32'(v.ram_we));
        check({v.name, "_rom_addr"}, o_rom_addr, v.rom_a);
        check({v.name, "_ram_addr"}, o_ram_addr, v.ram_a);
        if (v.ram_we) begin
            check({v.name, "_ram_be"}, 32'(o_ram_be), 32'(v.be));
            check({v.name, "_ram_wdata"}, o_ram_wdata, v.wdata);
        end
        check({v.name, "_ack_early"}, 32'(o_ack), 32'd0);
        cyc(); #1;
        check({v.name, "_ack"}, 32'(o_ack), 32'(3'b001 << v.port));
        check({v.name, "_err"}, 32'(o_err), 32'(v.err));
        check({v.name, "_rdata"}, o_rdata, v.rdata);
        check({v.name, "_ram_we_resp"}, 32'(o_ram_we), 32'd0);
        cyc(); #1;
        check({v.name, "_busy_idle"}, 32'(o_busy), 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        int          gc[3];
        int          ac[3];
        logic [31:0] ad[3];
        logic [2:0]  drop;
        int          ng;
        int          seq_p[5];
        int          seq_c[5];
        int          ns;
        int          we_base;

        //          name               port we addr          be     wdata          err rdata          rom_a       ram_a       ram_we
        vecs[0]  = mk("wr_ram_be3",     1, 1, 32'h0000_1008, 4'h3, 32'hDEAD_BEEF, 0, 32'h0,         32'h0,      32'h2,      1);
        vecs[1]  = mk("rd_ram_back",    0, 0, 32'h0000_1008, 4'hF, 32'h0,         0, 32'h0000_BEEF, 32'h0,      32'h2,      0);
        vecs[2]  = mk("rd_rom",         2, 0, 32'h0000_0010, 4'hF, 32'h0,         0, 32'hA000_0004, 32'h4,      32'h0,      0);
        vecs[3]  = mk("wr_rom_err",     0, 1, 32'h0000_0010, 4'hF, 32'h5555_5555, 1, 32'h0,         32'h0,      32'h0,      0);
        vecs[4]  = mk("rd_misalign",    1, 0, 32'h0000_0802, 4'hF, 32'h0,         1, 32'h0,         32'h0,      32'h0,      0);
        vecs[5]  = mk("rd_unmapped",    2, 0, 32'h0000_5000, 4'hF, 32'h0,         1, 32'h0,         32'h0,      32'h0,      0);
        vecs[6]  = mk("rd_rom_last",    0, 0, 32'h0000_07FC, 4'hF, 32'h0,         0, 32'hA000_01FF, 32'h1FF,    32'h0,      0);
        vecs[7]  = mk("rd_rom_end",     1, 0, 32'h0000_0800, 4'hF, 32'h0,         1, 32'h0,         32'h0,      32'h0,      0);
        vecs[8]  = mk("wr_ram_last",    2, 1, 32'h0000_4FFC, 4'hF, 32'hA5A5_5A5A, 0, 32'h0,         32'h0,      32'hFFF,    1);
        vecs[9]  = mk("rd_ram_last",    0, 0, 32'h0000_4FFC, 4'hF, 32'h0,         0, 32'hA5A5_5A5A, 32'h0,      32'hFFF,    0);
        vecs[10] = mk("wr_ram_first",   0, 1, 32'h0000_1000, 4'hF, 32'h1234_5678, 0, 32'h0,         32'h0,      32'h0,      1);
        vecs[11] = mk("rd_ram_first",   1, 0, 32'h0000_1000, 4'hF, 32'h0,         0, 32'h1234_5678, 32'h0,      32'h0,      0);
        vecs[12] = mk("rd_ram_misal",   0, 0, 32'h0000_1002, 4'hF, 32'h0,         1, 32'h0,         32'h0,      32'h0,      0);
        vecs[13] = mk("rd_below_ram",   2, 0, 32'h0000_0FFC, 4'hF, 32'h0,         1, 32'h0,         32'h0,      32'h0,      0);

        // ---- reset state (requests asserted while in reset) ----
        i_req = 3'b111;
        cyc(); cyc(); #1;
        check("rst_gnt", 32'(o_gnt), 32'd0);
        check("rst_ack", 32'(o_ack), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_ram_we", 32'(o_ram_we), 32'd0);
        check("rst_rom_addr", o_rom_addr, 32'd0);
        check("rst_ram_addr", o_ram_addr, 32'd0);
        i_req = '0;
        i_rst = 1'b0;
        cyc();

        // ---- table of single transactions ----
        for (int k = 0; k < 14; k++) run_txn(vecs[k]);

        // ---- fixed priority: three simultaneous ROM reads ----
        for (int p = 0; p < 3; p++) begin
            gc[p] = -1; ac[p] = -1; ad[p] = '0;
            drive(p, 1'b0, 32'(p * 4), 4'hF, 32'h0);
        end
        drop = '0;
        ng   = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                cyc();
                i_req = i_req & ~drop;
                drop  = '0;
            end
            #1;
            ng += $countones(o_gnt);
            for (int p = 0; p < 3; p++) begin
                if (o_gnt[p]) begin gc[p] = c; drop[p] = 1'b1; end
                if (o_ack[p]) begin ac[p] = c; ad[p] = o_rdata; end
            end
        end
        cyc();
        i_req = i_req & ~drop;
        #1;
        check("fix_gnt_count", 32'(ng), 32'd3);
        for (int p = 0; p < 3; p++) begin
            check($sformatf("fix_gnt_cycle_p%0d", p), 32'(gc[p]), 32'(3 * p));
            check($sformatf("fix_ack_cycle_p%0d", p), 32'(ac[p]), 32'(3 * p + 2));
            check($sformatf("fix_rdata_p%0d", p), ad[p], 32'hA000_0000 + 32'(p));
        end
        check("fix_idle_after", 32'(o_busy), 32'd0);

        // ---- round-robin: continuous requests on all ports ----
        i_rst = 1'b1;
        cyc(); cyc();
        i_rst = 1'b0;
        for (int p = 0; p < 3; p++) drive(p, 1'b0, 32'(p * 4), 4'hF, 32'h0);
        ns = 0;
        for (int k = 0; k < 5; k++) begin seq_p[k] = -1; seq_c[k] = -1; end
        for (int c = 0; c < 13; c++) begin
            if (c > 0) cyc();
            #1;
            for (int p = 0; p < 3; p++)
                if (rr_gnt[p] && ns < 5) begin seq_p[ns] = p; seq_c[ns] = c; ns++; end
        end
        cyc();
        i_req = '0;
        cyc(); cyc(); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_gnt_port_%0d", k), 32'(seq_p[k]), 32'(k % 3));
            check($sformatf("rr_gnt_cycle_%0d", k), 32'(seq_c[k]), 32'(3 * k));
        end
        check("rr_idle_after", 32'(rr_busy), 32'd0);

        // ---- clock enable low while in ACCESS of a RAM write ----
        we_base = we_cnt;
        drive(0, 1'b1, 32'h0000_1010, 4'hF, 32'hCAFE_F00D);
        #1;
        check("cen_gnt", 32'(o_gnt), 32'd1);
        cyc();
        i_req    = '0;
        i_clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            #1;
            check($sformatf("cen_hold_ram_we_%0d", k), 32'(o_ram_we), 32'd0);
            check($sformatf("cen_hold_ack_%0d", k), 32'(o_ack), 32'd0);
            check($sformatf("cen_hold_busy_%0d", k), 32'(o_busy), 32'd1);
        end
        cyc();
        i_clk_en = 1'b1;
        #1;
        check("cen_ram_we", 32'(o_ram_we), 32'd1);
        check("cen_ram_addr", o_ram_addr, 32'd4);
        check("cen_no_ack_yet", 32'(o_ack), 32'd0);
        cyc(); #1;
        check("cen_ack", 32'(o_ack), 32'd1);
        check("cen_err", 32'(o_err), 32'd0);
        cyc(); #1;
        check("cen_idle", 32'(o_busy), 32'd0);
        check("cen_we_pulses", 32'(we_cnt - we_base), 32'd1);
        // Grant is also suppressed in IDLE while the enable is low.
        i_clk_en = 1'b0;
        drive(1, 1'b0, 32'h0000_1010, 4'hF, 32'h0);
        #1;
        check("cen_gnt_blocked", 32'(o_gnt), 32'd0);
        cyc(); #1;
        check("cen_idle_held", 32'(o_busy), 32'd0);
        i_req    = '0;
        i_clk_en = 1'b1;
        cyc();
        run_txn(mk("cen_readback", 1, 0, 32'h0000_1010, 4'hF, 32'h0, 0,
                   32'hCAFE_F00D, 32'h0, 32'h4, 0));

        // ---- reset asserted during ACCESS of a write ----
        we_base = we_cnt;
        drive(2, 1'b1, 32'h0000_1020, 4'hF, 32'h1111_1111);
        #1;
        check("rstw_gnt", 32'(o_gnt), 32'd4);
        cyc();
        i_req = '0;
        i_rst = 1'b1;
        #1;
        check("rstw_ram_we", 32'(o_ram_we), 32'd0);
        check("rstw_ack", 32'(o_ack), 32'd0);
        cyc();
        i_rst = 1'b0;
        #1;
        check("rstw_busy", 32'(o_busy), 32'd0);
        check("rstw_gnt_after", 32'(o_gnt), 32'd0);
        check("rstw_err", 32'(o_err), 32'd0);
        check("rstw_rdata", o_rdata, 32'd0);
        check("rstw_ram_addr", o_ram_addr, 32'd0);
        check("rstw_rom_addr", o_rom_addr, 32'd0);
        check("rstw_ram_be", 32'(o_ram_be), 32'd0);
        check("rstw_ram_wdata", o_ram_wdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            check($sformatf("rstw_no_ack_%0d", k), 32'(o_ack), 32'd0);
        end
        check("rstw_we_pulses", 32'(we_cnt - we_base), 32'd0);
        run_txn(mk("rstw_readback", 0, 0, 32'h0000_1020, 4'hF, 32'h0, 0,
                   32'h0, 32'h0, 32'h8, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
